// File: rtl/cpx_mult_arbiter.sv
// Round-robin arbiter sharing one complex-multiplier pipeline between two requesters.
// Keeps the multiplier clocked with zero bubbles while tags are in flight and routes products back by tag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no requester granted; waits for enable and a valid request
// GRANT0  | requester 0 owns the multiplier; issues while req0_valid=1
// GRANT1  | requester 1 owns the multiplier; issues while req1_valid=1
module cpx_mult_arbiter #(
    parameter int DATA_BITS    = 12,
    parameter int PROD_BITS    = 24,
    parameter int MULT_LATENCY = 5,
    parameter int BURST_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DATA_BITS-1:0] req0_xi,
    input  logic [DATA_BITS-1:0] req0_xq,
    input  logic [DATA_BITS-1:0] req0_yi,
    input  logic [DATA_BITS-1:0] req0_yq,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DATA_BITS-1:0] req1_xi,
    input  logic [DATA_BITS-1:0] req1_xq,
    input  logic [DATA_BITS-1:0] req1_yi,
    input  logic [DATA_BITS-1:0] req1_yq,
    output logic                 mult_x_tvalid,
    output logic                 mult_y_tvalid,
    output logic [DATA_BITS-1:0] mult_xi,
    output logic [DATA_BITS-1:0] mult_xq,
    output logic [DATA_BITS-1:0] mult_yi,
    output logic [DATA_BITS-1:0] mult_yq,
    input  logic [PROD_BITS-1:0] mult_i,
    input  logic [PROD_BITS-1:0] mult_q,
    output logic                 res0_valid,
    output logic [PROD_BITS-1:0] res0_i,
    output logic [PROD_BITS-1:0] res0_q,
    output logic                 res1_valid,
    output logic [PROD_BITS-1:0] res1_i,
    output logic [PROD_BITS-1:0] res1_q,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;

    localparam int               CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    logic [1:0]              state, state_nxt;
    logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;
    logic                    rr_ptr, rr_ptr_nxt;
    logic [MULT_LATENCY-1:0] tag_vld, tag_id;
    logic [DATA_BITS-1:0]    hold_xi, hold_xq, hold_yi, hold_yq;

    logic granted, grant_id, own_valid, other_valid, at_limit, issue, tvalid;

    assign granted     = (state == S_GRANT0) || (state == S_GRANT1);
    assign grant_id    = (state == S_GRANT1);
    assign own_valid   = grant_id ? req1_valid : req0_valid;
    assign other_valid = grant_id ? req0_valid : req1_valid;
    assign at_limit    = (burst_cnt == CNT_MAX);

    // A full burst with the other side waiting blocks the holder so the switch wins.
    assign issue = granted && enable && own_valid && !(at_limit && other_valid);

    assign req0_ready    = issue && !grant_id;
    assign req1_ready    = issue && grant_id;
    assign busy          = |tag_vld;
    assign tvalid        = issue || busy;
    assign mult_x_tvalid = tvalid;
    assign mult_y_tvalid = tvalid;

    always_comb begin
        mult_xi = hold_xi;
        mult_xq = hold_xq;
        mult_yi = hold_yi;
        mult_yq = hold_yq;
        if (issue) begin
            mult_xi = grant_id ? req1_xi : req0_xi;
            mult_xq = grant_id ? req1_xq : req0_xq;
            mult_yi = grant_id ? req1_yi : req0_yi;
            mult_yq = grant_id ? req1_yq : req0_yq;
        end else if (busy) begin
            mult_xi = '0;
            mult_xq = '0;
            mult_yi = '0;
            mult_yq = '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        rr_ptr_nxt    = rr_ptr;
        case (state)
            S_IDLE: begin
                if (enable && (req0_valid || req1_valid)) begin
                    burst_cnt_nxt = '0;
                    if (req0_valid && req1_valid)
                        state_nxt = rr_ptr ? S_GRANT1 : S_GRANT0;
                    else
                        state_nxt = req1_valid ? S_GRANT1 : S_GRANT0;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (!enable) begin
                    state_nxt     = S_IDLE;
                    burst_cnt_nxt = '0;
                end else if (!own_valid) begin
                    burst_cnt_nxt = '0;
                    if (other_valid)
                        state_nxt = grant_id ? S_GRANT0 : S_GRANT1;
                    else
                        state_nxt = S_IDLE;
                end else if (other_valid && (at_limit || (issue && burst_cnt == CNT_LAST))) begin
                    // Switch on the edge that completes the burst so no grant slot is lost.
                    state_nxt     = grant_id ? S_GRANT0 : S_GRANT1;
                    burst_cnt_nxt = '0;
                    rr_ptr_nxt    = !grant_id;
                end else if (issue && !at_limit) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                burst_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            rr_ptr    <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
            hold_xi <= '0;
            hold_xq <= '0;
            hold_yi <= '0;
            hold_yq <= '0;
        end else if (tvalid) begin
            tag_vld[0] <= issue;
            tag_id[0]  <= issue ? grant_id : 1'b0;
            for (int s = 1; s < MULT_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            hold_xi <= mult_xi;
            hold_xq <= mult_xq;
            hold_yi <= mult_yi;
            hold_yq <= mult_yq;
        end
    end

    logic out_fire;
    assign out_fire = tvalid && tag_vld[MULT_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_i     <= '0;
            res0_q     <= '0;
            res1_i     <= '0;
            res1_q     <= '0;
        end else begin
            res0_valid <= out_fire && !tag_id[MULT_LATENCY-1];
            res1_valid <= out_fire && tag_id[MULT_LATENCY-1];
            if (out_fire && !tag_id[MULT_LATENCY-1]) begin
                res0_i <= mult_i;
                res0_q <= mult_q;
            end
            if (out_fire && tag_id[MULT_LATENCY-1]) begin
                res1_i <= mult_i;
                res1_q <= mult_q;
            end
        end
    end

endmodule

// File: doc/cpx_mult_arbiter.md
Name: cpx_mult_arbiter

Overview:
- Shares one complex-multiplier pipeline between two requesters, e.g. the reference and shifted streams of the CAF.
- Arbitration is round-robin with bounded bursts.
- The multiplier pipeline only advances on a valid input, so this block keeps it clocked with zero-operand bubbles until in-flight products drain.
- A tag pipeline matched to the multiplier latency routes each product back to its requester.

Parameters:
- DATA_BITS, 12, width of each operand component (xi, xq, yi, yq).
- PROD_BITS, 24, width of the multiplier i/q outputs and of the result ports.
- MULT_LATENCY, 5, cycles from an accepted multiplier input to the corresponding i/q output.
- BURST_LEN, 4, maximum consecutive grants to one requester while the other is waiting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  allow new grants
- reqN_valid  in  1  requester N (N=0,1) offers an operand pair
- reqN_ready  out  1  operand pair of requester N accepted this cycle
- reqN_xi, reqN_xq, reqN_yi, reqN_yq  in  DATA_BITS each  signed operands
- mult_x_tvalid, mult_y_tvalid  out  1 each  valid to the multiplier (always driven equal)
- mult_xi, mult_xq, mult_yi, mult_yq  out  DATA_BITS each  operands to the multiplier
- mult_i, mult_q  in  PROD_BITS each  multiplier products
- resN_valid  out  1  result for requester N
- resN_i, resN_q  out  PROD_BITS each  signed product
- busy  out  1  any tag in flight

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, tag pipe cleared, burst counter 0, round-robin pointer set to requester 0.
- Reset asserted mid-operation discards all in-flight products; no resN_valid is produced for them after release.
- FSM states: IDLE, GRANT0, GRANT1.
  - IDLE: if enable=1 and any reqN_valid=1, go to GRANTk. k is the valid requester; if both are valid, k is the round-robin pointer.
  - GRANTk, reqk_valid=1: issue reqk's operands and increment the burst counter.
  - GRANTk, reqk_valid=0: switch to the other requester if it is valid, else go to IDLE.
  - GRANTk, burst counter = BURST_LEN and the other requester is valid: switch to it. The counter clears and the pointer moves to the other requester.
  - enable=0: go to IDLE at the next edge. An issue already committed in the current cycle completes.
- Issue is combinational in the granted cycle:
  - reqk_ready = 1 exactly when operands from reqk drive mult_* this cycle.
  - Each cycle at most one ready is high.
  - Requester data must be held stable while reqk_valid=1 and ready=0.
- Bubbles:
  - When no request is issued and busy=1, mult_*_tvalid=1 with all mult operands 0.
  - When not issuing and busy=0, mult_*_tvalid=0 and the operands hold their last value.
- Tag pipe:
  - MULT_LATENCY stages of {valid, id}, shifted on every cycle in which mult_*_tvalid=1.
  - Stage 0 = {issued, k}. Bubbles insert {0, x}.
  - A tag leaving the last stage with valid=1 registers mult_i/mult_q into res{id}_i/q and pulses res{id}_valid for one cycle.
  - Total latency from reqk_ready high to resk_valid high is MULT_LATENCY+1 cycles when the pipe advances every cycle.
- Results are never back-pressured. resN_i/q hold their value when resN_valid=0.
- busy = OR of the valid bits in the tag pipe.
- Ordering: results for each requester return in issue order. Interleaving across requesters follows issue order.
- Both requesters are valid in the same cycle as the burst limit is reached: the switch takes priority; no third consecutive decision favours the holder.
- Widths: products pass through unmodified; no rounding or saturation in this block.

Test Plan:
- Single issue: req0 sends xi=3, xq=2, yi=4, yq=-1 once -> exactly one res0_valid, 6 cycles after ready. res0_i=14, res0_q=5; res1_valid stays 0; busy falls after the drain.
- Drain with bubbles: one request, then both requesters idle -> mult_*_tvalid stays 1 for 5 bubble cycles, then drops to 0 once busy=0. No spurious resN_valid.
- Contention: both requesters continuously valid, BURST_LEN=4 -> grants 0,0,0,0,1,1,1,1,0... Result ids arrive in the same order, 6 cycles delayed. Products are correct for distinct operands, e.g. (1+1j)(1-1j)=2+0j and (-2048)(-2048)=4194304 on the i path.
- Enable drop: enable->0 mid-burst -> no further ready. All previously accepted products are still returned.
- Reset mid-flight: rst_n low for 1 cycle with 3 tags in flight -> all outputs 0 immediately. No resN_valid follows after release; a new request afterwards returns normally.
- Single requester hold: only req1 valid for 10 cycles -> 10 consecutive grants to req1 with no burst-limit gap; 10 results returned in order.
